// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational ALU: queues register-file
// commands in a small FIFO and executes them one at a time (MUL takes two writebacks).
module alu_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_sig,
  input  logic [1:0]        cmd_src1,
  input  logic [1:0]        cmd_src2,
  input  logic [1:0]        cmd_dst,
  input  logic [15:0]       cmd_imm,
  output logic [1:0]        alu_sel1,
  output logic [1:0]        alu_sel2,
  output logic              alu_sig,
  output logic              alu_op,
  input  logic [15:0]       alu_out1,
  input  logic [15:0]       alu_out2,
  input  logic              alu_flag,
  output logic [3:0][15:0]  R,
  output logic              flag,
  output logic              busy,
  output logic              done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_MUL   = 2'b01,
    OP_LOADI = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EXEC  = 2'b01,
    WB_HI = 2'b10
  } state_e;

  typedef struct packed {
    op_e         op;
    logic        sig;
    logic [1:0]  src1;
    logic [1:0]  src2;
    logic [1:0]  dst;
    logic [15:0] imm;
  } cmd_t;

  cmd_t        mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  cmd_t        cmd_in;
  cmd_t        head;

  state_e      state;
  cmd_t        ir;
  logic [15:0] hi_hold;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    cmd_ready  = ~fifo_full;
    push       = cmd_valid && ~fifo_full;
    pop        = (state == IDLE) && run && ~fifo_empty;
    head       = mem[rd_ptr[AW-1:0]];
    cmd_in     = '{op: op_e'(cmd_op), sig: cmd_sig, src1: cmd_src1,
                   src2: cmd_src2, dst: cmd_dst, imm: cmd_imm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= cmd_in;
    end
  end

  // ALU controls are registered at pop so they are stable for the whole EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      ir       <= '0;
      hi_hold  <= '0;
      R        <= '0;
      flag     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      alu_sel1 <= '0;
      alu_sel2 <= '0;
      alu_sig  <= 1'b0;
      alu_op   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            ir       <= head;
            rd_ptr   <= rd_ptr + PTR_ONE;
            state    <= EXEC;
            busy     <= 1'b1;
            alu_sel1 <= head.src1;
            alu_sel2 <= head.src2;
            alu_sig  <= head.sig;
            alu_op   <= (head.op == OP_MUL);
          end
        end
        EXEC: begin
          alu_sel1 <= '0;
          alu_sel2 <= '0;
          alu_sig  <= 1'b0;
          alu_op   <= 1'b0;
          case (ir.op)
            OP_ADD: begin
              R[ir.dst] <= alu_out1;
              flag      <= alu_flag;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
            OP_MUL: begin
              // High half is latched now so a low write onto a source cannot disturb it.
              R[ir.dst] <= alu_out1;
              hi_hold   <= alu_out2;
              state     <= WB_HI;
            end
            OP_LOADI: begin
              R[ir.dst] <= ir.imm;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
            default: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          endcase
        end
        WB_HI: begin
          R[ir.dst + 2'd1] <= hi_hold;
          done             <= 1'b1;
          busy             <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; includes a behavioural 16-bit ALU on the alu_* ports.
module tb_alu_sequencer;

  logic             clk = 1'b0;
  logic             rst_n, run, cmd_valid, cmd_ready, cmd_sig;
  logic [1:0]       cmd_op, cmd_src1, cmd_src2, cmd_dst;
  logic [15:0]      cmd_imm;
  logic [1:0]       alu_sel1, alu_sel2;
  logic             alu_sig, alu_op, alu_flag;
  logic [15:0]      alu_out1, alu_out2;
  logic [3:0][15:0] R;
  logic             flag, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  localparam logic [1:0] ADD = 2'b00, MUL = 2'b01, LDI = 2'b10;

  alu_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sig(cmd_sig), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
    .cmd_dst(cmd_dst), .cmd_imm(cmd_imm), .alu_sel1(alu_sel1), .alu_sel2(alu_sel2),
    .alu_sig(alu_sig), .alu_op(alu_op), .alu_out1(alu_out1), .alu_out2(alu_out2),
    .alu_flag(alu_flag), .R(R), .flag(flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  logic [15:0] op_a, op_b;
  logic [16:0] sum17;
  logic [31:0] prod;
  always_comb begin
    op_a  = R[alu_sel1];
    op_b  = R[alu_sel2];
    sum17 = {1'b0, op_a} + {1'b0, op_b};
    if (alu_sig) prod = {{16{op_a[15]}}, op_a} * {{16{op_b[15]}}, op_b};
    else         prod = {16'h0000, op_a} * {16'h0000, op_b};
    if (alu_op) begin
      alu_out1 = prod[15:0];
      alu_out2 = prod[31:16];
      alu_flag = 1'b0;
    end else begin
      alu_out1 = sum17[15:0];
      alu_out2 = 16'h0000;
      alu_flag = alu_sig ? ((op_a[15] == op_b[15]) && (sum17[15] != op_a[15])) : sum17[16];
    end
  end

  task automatic push(input logic [1:0] op, input logic sig, input logic [1:0] s1,
                      input logic [1:0] s2, input logic [1:0] d, input logic [15:0] imm);
    cmd_op = op; cmd_sig = sig; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done_cnt >= target) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_sig = 1'b0; cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0; cmd_imm = '0;
    #2;
    n_checks++; if (R !== '0) $display("FAIL reset_R: got %h exp 0", R); else n_pass++;
    n_checks++; if ({flag, busy, done} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {flag, busy, done}); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", cmd_ready); else n_pass++;
    n_checks++; if ({alu_sel1, alu_sel2, alu_sig, alu_op} !== 6'b0) $display("FAIL reset_alu: got %b exp 000000", {alu_sel1, alu_sel2, alu_sig, alu_op}); else n_pass++;
    @(negedge clk); rst_n = 1'b1; run = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_signed_add;
    int base; bit ok;
    base = done_cnt;
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd0, 16'h7FFF);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0001);
    push(ADD, 1'b1, 2'd0, 2'd1, 2'd2, 16'h0000);
    wait_done(base + 3, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (ok !== 1'b1) $display("FAIL sadd_timeout: got %0d dones exp %0d", done_cnt - base, 3); else n_pass++;
    n_checks++; if (R[2] !== 16'h8000) $display("FAIL sadd_r2: got %h exp 8000", R[2]); else n_pass++;
    n_checks++; if (flag !== 1'b1) $display("FAIL sadd_flag: got %b exp 1", flag); else n_pass++;
    n_checks++; if (done_cnt - base !== 3) $display("FAIL sadd_done_count: got %0d exp 3", done_cnt - base); else n_pass++;
  endtask

  task automatic test_unsigned_add;
    int base; bit ok;
    base = done_cnt;
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd0, 16'hFFFF);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0001);
    push(ADD, 1'b0, 2'd0, 2'd1, 2'd3, 16'h0000);
    wait_done(base + 3, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL uadd_timeout: got %0d dones exp 3", done_cnt - base); else n_pass++;
    n_checks++; if (R[3] !== 16'h0000) $display("FAIL uadd_carry_r3: got %h exp 0000", R[3]); else n_pass++;
    n_checks++; if (flag !== 1'b1) $display("FAIL uadd_carry_flag: got %b exp 1", flag); else n_pass++;
    push(ADD, 1'b0, 2'd1, 2'd1, 2'd3, 16'h0000);
    wait_done(base + 4, ok);
    n_checks++; if (R[3] !== 16'h0002) $display("FAIL uadd_r3: got %h exp 0002", R[3]); else n_pass++;
    n_checks++; if (flag !== 1'b0) $display("FAIL uadd_flag: got %b exp 0", flag); else n_pass++;
  endtask

  task automatic test_mul_latency;
    int base; bit ok;
    base = done_cnt;
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd2, 16'hFFFF);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd3, 16'h0001);
    push(ADD, 1'b0, 2'd2, 2'd3, 2'd2, 16'h0000);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0100);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0100);
    wait_done(base + 5, ok);
    n_checks++; if (flag !== 1'b1) $display("FAIL mul_pre_flag: got %b exp 1", flag); else n_pass++;
    push(MUL, 1'b0, 2'd0, 2'd1, 2'd3, 16'h0000);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL mul_t0_busy: got %b exp 0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if ({busy, alu_op, alu_sig, alu_sel1, alu_sel2} !== 7'b1100001) $display("FAIL mul_exec_ctrl: got %b exp 1100001", {busy, alu_op, alu_sig, alu_sel1, alu_sel2}); else n_pass++;
    n_checks++; if (R[3] !== 16'h0001) $display("FAIL mul_t1_r3: got %h exp 0001", R[3]); else n_pass++;
    @(negedge clk);
    n_checks++; if (R[3] !== 16'h0000) $display("FAIL mul_t2_r3: got %h exp 0000", R[3]); else n_pass++;
    n_checks++; if ({R[0], done} !== {16'h0100, 1'b0}) $display("FAIL mul_t2_r0_done: got %h/%b exp 0100/0", R[0], done); else n_pass++;
    @(negedge clk);
    n_checks++; if ({R[0], done} !== {16'h0001, 1'b1}) $display("FAIL mul_t3_r0_done: got %h/%b exp 0001/1", R[0], done); else n_pass++;
    n_checks++; if (flag !== 1'b1) $display("FAIL mul_flag_kept: got %b exp 1", flag); else n_pass++;
    @(negedge clk);
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL mul_after: got %b exp 00", {busy, done}); else n_pass++;
  endtask

  task automatic test_signed_mul;
    int base; bit ok;
    base = done_cnt;
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd0, 16'hFFFF);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0002);
    push(MUL, 1'b1, 2'd0, 2'd1, 2'd0, 16'h0000);
    wait_done(base + 3, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL smul_timeout: got %0d dones exp 3", done_cnt - base); else n_pass++;
    n_checks++; if (R[0] !== 16'hFFFE) $display("FAIL smul_lo: got %h exp FFFE", R[0]); else n_pass++;
    n_checks++; if (R[1] !== 16'hFFFF) $display("FAIL smul_hi: got %h exp FFFF", R[1]); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  ops  [5] = '{LDI, LDI, LDI, LDI, ADD};
    logic [1:0]  dsts [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] imms [5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0000};
    int base; bit ok; bit accepted;
    base = done_cnt;
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_op = ops[i]; cmd_sig = 1'b0; cmd_src1 = 2'd0; cmd_src2 = 2'd1;
      cmd_dst = dsts[i]; cmd_imm = imms[i]; cmd_valid = 1'b1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b exp 1", i, cmd_ready); else n_pass++;
      @(posedge clk);
    end
    #1 cmd_op = ops[4]; cmd_dst = dsts[4]; cmd_imm = imms[4];
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_full: got %b exp 0", cmd_ready); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if ({cmd_ready, busy} !== 2'b00) $display("FAIL b2b_held: got %b exp 00", {cmd_ready, busy}); else n_pass++;
    n_checks++; if (R[0] !== 16'hFFFE) $display("FAIL b2b_no_exec: got %h exp FFFE", R[0]); else n_pass++;
    run = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin @(posedge clk); accepted = 1'b1; end
    end
    #1 cmd_valid = 1'b0;
    n_checks++; if (accepted !== 1'b1) $display("FAIL b2b_fifth_accept: got %b exp 1", accepted); else n_pass++;
    wait_done(base + 5, ok);
    repeat (4) @(negedge clk);
    n_checks++; if (done_cnt - base !== 5) $display("FAIL b2b_done_count: got %0d exp 5", done_cnt - base); else n_pass++;
    n_checks++; if (R !== {16'h0044, 16'h0033, 16'h0022, 16'h0033}) $display("FAIL b2b_regs: got %h exp 0044003300220033", R); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int base; bit ok;
    base = done_cnt;
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd2, 16'hFFFF);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd3, 16'h0001);
    push(ADD, 1'b0, 2'd2, 2'd3, 2'd2, 16'h0000);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0100);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0100);
    wait_done(base + 5, ok);
    push(MUL, 1'b0, 2'd0, 2'd1, 2'd3, 16'h0000);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd2, 16'h0055);
    push(LDI, 1'b0, 2'd0, 2'd0, 2'd3, 16'h0066);
    @(negedge clk);
    n_checks++; if ({busy, R[3], flag} !== {1'b1, 16'h0000, 1'b1}) $display("FAIL rmid_in_wbhi: got %b/%h/%b exp 1/0000/1", busy, R[3], flag); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (R !== '0) $display("FAIL rmid_regs: got %h exp 0", R); else n_pass++;
    n_checks++; if ({busy, done, flag, cmd_ready} !== 4'b0001) $display("FAIL rmid_status: got %b exp 0001", {busy, done, flag, cmd_ready}); else n_pass++;
    base = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++; if (R !== '0) $display("FAIL rmid_no_writes: got %h exp 0", R); else n_pass++;
    n_checks++; if ({done_cnt - base, busy} !== {32'd0, 1'b0}) $display("FAIL rmid_idle: got dones %0d busy %b exp 0/0", done_cnt - base, busy); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_signed_add();
    test_unsigned_add();
    test_mul_latency();
    test_signed_mul();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
